// File: rtl/pw_pkg.sv
// Shared types and helpers for the switch-based password digit entry stage.
// Holds the FSM state encoding and the switch-vector-to-digit decoder.
package pw_pkg;

  localparam int DIGIT_W = 4;
  localparam int MAX_SW  = 16;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_WAIT_REL = 2'd1,
    ST_PRESENT  = 2'd2
  } state_t;

  // Result of decoding a switch vector: index of the (highest) set bit,
  // plus flags telling whether no bit or more than one bit was set.
  typedef struct packed {
    logic                multi;
    logic                none;
    logic [DIGIT_W-1:0]  idx;
  } sel_t;

  function automatic sel_t onehot_to_index(input logic [MAX_SW-1:0] v);
    sel_t r;
    int   n;
    r = '0;
    n = 0;
    for (int k = 0; k < MAX_SW; k++) begin
      if (v[k]) begin
        r.idx = k[DIGIT_W-1:0];
        n++;
      end
    end
    r.multi = (n > 1);
    r.none  = (n == 0);
    return r;
  endfunction

endpackage

// File: rtl/pw_digit_entry_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for the digit switches.
// sw_db follows the synchronised vector only after it has been stable for CYCLES clocks.
module sw_debounce #(
  parameter int W      = 10,
  parameter int CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_in,
  output logic [W-1:0] sw_db
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0]  sync1_reg;
  logic [W-1:0]  sw_s;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sw_s      <= '0;
    end else begin
      sync1_reg <= sw_in;
      sw_s      <= sync1_reg;
    end
  end

  // sync1_reg != sw_s means sw_s is about to change, so the count restarts
  // in the same cycle the new value lands; this keeps the latency at 2+CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      sw_db   <= '0;
    end else if (sync1_reg != sw_s) begin
      cnt_reg <= '0;
    end else if (sw_s != sw_db) begin
      if (cnt_reg == CW'(CYCLES - 1)) begin
        sw_db   <= sw_s;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/pw_digit_entry.sv
// Digit entry front end of the password lock: debounced switches become digit
// strobes, N_DIGITS digits are assembled and offered to the checker via valid/ready.
module pw_digit_entry
  import pw_pkg::*;
#(
  parameter int N_SW            = 10,
  parameter int N_DIGITS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SW-1:0]             sw_in,
  input  logic                        clear,
  input  logic                        code_ready,
  output logic                        code_valid,
  output logic [DIGIT_W*N_DIGITS-1:0] code_out,
  output logic [3:0]                  digit_count,
  output logic                        digit_strobe,
  output logic [3:0]                  digit_last,
  output logic                        err_multi
);

  localparam int CODE_W = DIGIT_W * N_DIGITS;

  logic [N_SW-1:0]   sw_db;
  logic [MAX_SW-1:0] sw_db_ext;
  sel_t              sel;
  logic [CODE_W-1:0] buffer_reg;
  logic [CODE_W-1:0] buffer_shift;
  logic [3:0]        count_next;
  state_t            state_reg;

  sw_debounce #(
    .W      (N_SW),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .sw_in (sw_in),
    .sw_db (sw_db)
  );

  always_comb begin
    sw_db_ext             = '0;
    sw_db_ext[N_SW-1:0]   = sw_db;
  end

  assign sel          = onehot_to_index(sw_db_ext);
  // Oldest digit ends up in the MS nibble once N_DIGITS digits are shifted in.
  assign buffer_shift = CODE_W'({buffer_reg, sel.idx});
  assign count_next   = digit_count + 4'd1;
  assign code_out     = buffer_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_WAIT_REL;
      buffer_reg   <= '0;
      digit_count  <= '0;
      code_valid   <= 1'b0;
      digit_strobe <= 1'b0;
      digit_last   <= '0;
      err_multi    <= 1'b0;
    end else begin
      digit_strobe <= 1'b0;
      err_multi    <= 1'b0;
      // clear wins over a same-cycle capture or handshake
      if (clear) begin
        buffer_reg  <= '0;
        digit_count <= '0;
        code_valid  <= 1'b0;
        state_reg   <= ST_WAIT_REL;
      end else begin
        case (state_reg)
          ST_ARMED: begin
            if (sel.multi) begin
              err_multi <= 1'b1;
              state_reg <= ST_WAIT_REL;
            end else if (!sel.none) begin
              digit_strobe <= 1'b1;
              digit_last   <= sel.idx;
              buffer_reg   <= buffer_shift;
              digit_count  <= count_next;
              if (count_next == 4'(N_DIGITS)) begin
                code_valid <= 1'b1;
                state_reg  <= ST_PRESENT;
              end else begin
                state_reg  <= ST_WAIT_REL;
              end
            end
          end
          ST_WAIT_REL: begin
            if (sel.none) begin
              state_reg <= ST_ARMED;
            end
          end
          ST_PRESENT: begin
            if (code_valid && code_ready) begin
              buffer_reg  <= '0;
              digit_count <= '0;
              code_valid  <= 1'b0;
              state_reg   <= ST_WAIT_REL;
            end
          end
          default: begin
            state_reg <= ST_WAIT_REL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pw_digit_entry.sv
// Scoreboard bench for pw_digit_entry: stimulus queues expected strobes/errors/codes,
// a negedge monitor pops and compares them whenever the DUT presents an event.
module tb_pw_digit_entry;

  localparam int N_SW = 10;
  localparam int N_DIGITS = 4;
  localparam int DEB = 4;

  typedef enum logic [1:0] {EV_STROBE = 2'd0, EV_ERR = 2'd1, EV_CODE = 2'd2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sw_in = '0;
  logic        clear = 1'b0;
  logic        code_ready = 1'b0;
  logic        code_valid;
  logic [15:0] code_out;
  logic [3:0]  digit_count;
  logic        digit_strobe;
  logic [3:0]  digit_last;
  logic        err_multi;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  pw_digit_entry #(
    .N_SW            (N_SW),
    .N_DIGITS        (N_DIGITS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .clear        (clear),
    .code_ready   (code_ready),
    .code_valid   (code_valid),
    .code_out     (code_out),
    .digit_count  (digit_count),
    .digit_strobe (digit_strobe),
    .digit_last   (digit_last),
    .err_multi    (err_multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [15:0] d, input string name);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event data=%h, required no event", name, d);
    end else begin
      e = sb_q.pop_front();
      check(name, {14'd0, k, d}, {14'd0, e.kind, e.data});
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard pop per DUT event
  always @(negedge clk) begin
    if (!rst) begin
      if (digit_strobe) expect_ev(EV_STROBE, {8'h00, digit_count, digit_last}, "strobe");
      if (err_multi)    expect_ev(EV_ERR, 16'h0000, "err_multi");
      if (code_valid && code_ready) expect_ev(EV_CODE, code_out, "code");
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int d, input int cnt);
    push(EV_STROBE, {8'h00, 4'(cnt), 4'(d)});
    sw_in = 10'(1 << d);
    tick(20);
    sw_in = '0;
    tick(20);
  endtask

  task automatic handshake(input logic [15:0] exp_code);
    push(EV_CODE, exp_code);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    check("valid_after_hs", {31'd0, code_valid}, 32'd0);
    check("count_after_hs", {28'd0, digit_count}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {code_valid, digit_strobe, err_multi, digit_count, digit_last, code_out}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    tick(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    tick(5);

    // 1: basic 4-digit entry 3,7,0,9
    press(3, 1);
    press(7, 2);
    press(0, 3);
    press(9, 4);
    check("t1_valid", {31'd0, code_valid}, 32'd1);
    check("t1_code", {16'd0, code_out}, 32'h3709);
    tick(10);
    check("t1_valid_hold", {31'd0, code_valid}, 32'd1);
    handshake(16'h3709);

    // 2: bouncing sw[5]
    push(EV_STROBE, {8'h00, 4'd1, 4'd5});
    repeat (3) begin
      sw_in = 10'(1 << 5);
      tick(1);
      sw_in = '0;
      tick(1);
    end
    sw_in = 10'(1 << 5);
    tick(20);
    sw_in = '0;
    tick(20);
    check("t2_digit_last", {28'd0, digit_last}, 32'd5);

    // 3: two switches together, then partial release, then full release
    push(EV_ERR, 16'h0000);
    sw_in = 10'h044;
    tick(20);
    check("t3_count", {28'd0, digit_count}, 32'd1);
    sw_in = 10'h004;
    tick(20);
    sw_in = '0;
    tick(20);
    press(1, 2);

    // 4: clear coinciding with a one-hot sw_db
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t4_clear_count", {28'd0, digit_count}, 32'd0);
    press(4, 1);
    press(8, 2);
    sw_in = 10'(1 << 6);
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(10);
    check("t4_count", {28'd0, digit_count}, 32'd0);
    check("t4_valid", {31'd0, code_valid}, 32'd0);
    sw_in = '0;
    tick(20);
    press(1, 1);
    press(2, 2);
    press(3, 3);
    press(4, 4);
    handshake(16'h1234);

    // 5: activity in PRESENT is ignored; held switch after handshake gives nothing
    press(8, 1);
    press(6, 2);
    press(5, 3);
    press(0, 4);
    for (int i = 0; i < 3; i++) begin
      sw_in = 10'(1 << (i + 1));
      tick(10);
      sw_in = '0;
      tick(10);
    end
    check("t5_code_stable", {16'd0, code_out}, 32'h8650);
    check("t5_valid_stable", {31'd0, code_valid}, 32'd1);
    sw_in = 10'(1 << 7);
    tick(20);
    handshake(16'h8650);
    tick(20);
    check("t5_no_digit_held", {28'd0, digit_count}, 32'd0);
    sw_in = '0;
    tick(20);
    press(2, 1);

    // 6: async reset mid-debounce and in PRESENT
    sw_in = 10'(1 << 3);
    tick(3);
    #2 rst = 1'b1;
    #1 check_all_zero("t6_rst_debounce");
    sw_in = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    press(9, 1);
    press(1, 2);
    press(1, 3);
    press(9, 4);
    check("t6_code_pre_rst", {16'd0, code_out}, 32'h9119);
    #3 rst = 1'b1;
    #1 check_all_zero("t6_rst_present");
    tick(3);
    rst = 1'b0;
    tick(10);
    press(4, 1);
    press(3, 2);
    press(2, 3);
    press(1, 4);
    handshake(16'h4321);

    tick(10);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
